// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Requesters are served round-robin, one operation at a time. The ALU
// operands are held stable for a per-opcode number of cycles, and the
// result is handed back on a valid/ready response channel.
// Divide-by-zero is trapped and answered without touching the ALU inputs.
module alu_arbiter #(
    parameter int WIDTH      = 16,
    parameter int MULDIV_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_select,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_carry,
    output logic             resp_err,
    output logic             resp_id,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter preload for mult/divide; the final EXEC cycle is the cnt==0 one.
    localparam logic [3:0] MULDIV_CNT = 4'(MULDIV_LAT - 1);

    state_t           state_q, state_d;
    logic             rr_last_q, rr_last_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic             resp_carry_q, resp_carry_d;
    logic             resp_err_q, resp_err_d;
    logic             resp_id_q, resp_id_d;

    logic             any_valid;
    logic             grant;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [2:0]       sel_op;

    // Round-robin pick: a lone requester wins, on a tie the one not served last wins.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~rr_last_q;
        end else begin
            grant = req1_valid;
        end
        sel_a  = grant ? req1_a  : req0_a;
        sel_b  = grant ? req1_b  : req0_b;
        sel_op = grant ? req1_op : req0_op;
    end

    assign req0_ready = (state_q == IDLE) && req0_valid && !grant;
    assign req1_ready = (state_q == IDLE) && req1_valid &&  grant;

    // Next-state logic for the controller and every datapath register.
    always_comb begin
        state_d      = state_q;
        rr_last_d    = rr_last_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        resp_data_d  = resp_data_q;
        resp_carry_d = resp_carry_q;
        resp_err_d   = resp_err_q;
        resp_id_d    = resp_id_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    rr_last_d = grant;
                    resp_id_d = grant;
                    if (sel_op == 3'b111 && sel_b == '0) begin
                        // Trapped divide: answer directly, ALU inputs keep their old value.
                        resp_data_d  = '1;
                        resp_carry_d = 1'b0;
                        resp_err_d   = 1'b1;
                        state_d      = RESP;
                    end else begin
                        a_d     = sel_a;
                        b_d     = sel_b;
                        op_d    = sel_op;
                        cnt_d   = (sel_op[2:1] == 2'b11) ? MULDIV_CNT : 4'd0;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    resp_data_d  = alu_result;
                    resp_carry_d = alu_carry;
                    resp_err_d   = 1'b0;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset; requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_last_q    <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            cnt_q        <= '0;
            resp_data_q  <= '0;
            resp_carry_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_id_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_last_q    <= rr_last_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            resp_data_q  <= resp_data_d;
            resp_carry_q <= resp_carry_d;
            resp_err_q   <= resp_err_d;
            resp_id_q    <= resp_id_d;
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_select = op_q;
    assign resp_valid = (state_q == RESP);
    assign resp_data  = resp_data_q;
    assign resp_carry = resp_carry_q;
    assign resp_err   = resp_err_q;
    assign resp_id    = resp_id_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: a behavioural ALU feeds the DUT, and a
// transaction-level model predicts grants, response timing and contents.
module tb_alu_arbiter;
    localparam int W   = 16;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic [2:0]    req0_op, req1_op;
    logic [W-1:0]  alu_a, alu_b, alu_result;
    logic [2:0]    alu_select;
    logic          alu_carry;
    logic          resp_valid, resp_ready;
    logic [W-1:0]  resp_data;
    logic          resp_carry, resp_err, resp_id, busy;
    logic [W:0]    alu_out;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Transaction model
    bit            m_busy, m_inresp, m_rr;
    int            m_due;
    logic [W-1:0]  m_alu_a, m_alu_b, e_data;
    logic [2:0]    m_sel;
    logic          e_carry, e_err, e_id;
    bit            p [2];
    logic [W-1:0]  pa [2];
    logic [W-1:0]  pb [2];
    logic [2:0]    pop [2];

    always #5 clk = ~clk;

    // Reference ALU: {carry, result}
    function automatic logic [W:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] op);
        logic [W-1:0] prod;
        case (op)
            3'd0: return {1'b0, a & b};
            3'd1: return {1'b0, a | b};
            3'd2: return {1'b0, a ^ b};
            3'd3: return {1'b0, ~a};
            3'd4: return {1'b0, a} + {1'b0, b};
            3'd5: return {1'b0, a} - {1'b0, b};
            3'd6: begin prod = a * b; return {1'b0, prod}; end
            default: return (b == '0) ? {1'b0, 16'hFFFF} : {1'b0, a / b};
        endcase
    endfunction

    assign alu_out    = alu_f(alu_a, alu_b, alu_select);
    assign alu_result = alu_out[W-1:0];
    assign alu_carry  = alu_out[W];

    alu_arbiter #(.WIDTH(W), .MULDIV_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_carry(resp_carry),
        .resp_err(resp_err), .resp_id(resp_id), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_inresp = 0; m_rr = 1; m_due = 0;
        m_alu_a = '0; m_alu_b = '0; m_sel = '0;
        e_data = '0; e_carry = 0; e_err = 0; e_id = 0;
    endtask

    // One clock cycle: drive, check against model, advance model over the edge.
    task automatic step(input bit do_rst, input bit rready);
        int win;
        bit acc;
        rst = do_rst; resp_ready = rready;
        req0_valid = p[0]; req0_a = pa[0]; req0_b = pb[0]; req0_op = pop[0];
        req1_valid = p[1]; req1_a = pa[1]; req1_b = pb[1]; req1_op = pop[1];
        #1;
        win = (p[0] && p[1]) ? (m_rr ? 0 : 1) : (p[1] ? 1 : 0);
        acc = !m_busy && (p[0] || p[1]) && !do_rst;
        if (!do_rst) begin
            chk("req0_ready", req0_ready, acc && win == 0);
            chk("req1_ready", req1_ready, acc && win == 1);
        end
        chk("resp_valid", resp_valid, m_inresp);
        chk("busy", busy, m_busy);
        chk("alu_a", alu_a, m_alu_a);
        chk("alu_b", alu_b, m_alu_b);
        chk("alu_select", alu_select, m_sel);
        if (m_inresp) begin
            chk("resp_data", resp_data, e_data);
            chk("resp_carry", resp_carry, e_carry);
            chk("resp_err", resp_err, e_err);
            chk("resp_id", resp_id, e_id);
        end
        if (do_rst) begin
            model_reset();
        end else if (acc) begin
            $display("txn id=%0d op=%0d a=%h b=%h", win, pop[win], pa[win], pb[win]);
            m_rr = win[0]; e_id = win[0]; m_busy = 1;
            if (pop[win] == 3'd7 && pb[win] == '0) begin
                e_data = 16'hFFFF; e_carry = 0; e_err = 1; m_inresp = 1;
            end else begin
                m_alu_a = pa[win]; m_alu_b = pb[win]; m_sel = pop[win];
                {e_carry, e_data} = alu_f(pa[win], pb[win], pop[win]);
                e_err = 0;
                m_due = (pop[win] >= 3'd6) ? LAT : 1;
            end
            p[win] = 0;
        end else if (m_inresp) begin
            if (rready) begin m_busy = 0; m_inresp = 0; end
        end else if (m_busy) begin
            m_due--;
            if (m_due == 0) m_inresp = 1;
        end
        @(posedge clk); #1;
    endtask

    task automatic set_req(input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] op);
        p[n] = 1; pa[n] = a; pb[n] = b; pop[n] = op;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin p[i] = 0; pa[i] = '0; pb[i] = '0; pop[i] = '0; end
        rst = 1; resp_ready = 0;
        req0_valid = 0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_op = '0;
        model_reset();
        @(posedge clk); #1;
        step(1, 0);
        chk("rst_resp_data", resp_data, 16'h0000);
        chk("rst_resp_carry", resp_carry, 1'b0);
        chk("rst_resp_err", resp_err, 1'b0);
        chk("rst_resp_id", resp_id, 1'b0);

        // Single add with carry out
        set_req(0, 16'hFFFF, 16'h0001, 3'b100);
        for (int i = 0; i < 3; i++) step(0, 0);
        step(0, 1);
        step(0, 0);

        // Multiply from requester 1, response held under backpressure
        set_req(1, 16'd300, 16'd200, 3'b110);
        for (int i = 0; i < 10; i++) step(0, 0);
        step(0, 1);

        // Divide by zero: trapped, ALU select untouched
        set_req(0, 16'd100, 16'd0, 3'b111);
        step(0, 0);
        step(0, 1);

        // Contention with adds
        for (int k = 0; k < 4; k++) begin
            if (!p[0]) set_req(0, 16'(k * 11), 16'(k + 3), 3'b000);
            if (!p[1]) set_req(1, 16'(k * 7), 16'(k + 5), 3'b000);
            step(0, 0); step(0, 0); step(0, 1);
        end
        for (int i = 0; i < 6; i++) step(0, 1);

        // Reset in the middle of a divide; requester 0 must win afterwards
        set_req(0, 16'd1000, 16'd7, 3'b111);
        step(0, 0);
        step(0, 0);
        step(1, 0);
        set_req(0, 16'h1234, 16'h0F0F, 3'b010);
        set_req(1, 16'h4321, 16'h00FF, 3'b001);
        for (int i = 0; i < 8; i++) step(0, 1);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!p[n] && ($urandom % 3 == 0))
                    set_req(n, 16'($urandom), ($urandom % 4 == 0) ? 16'h0 : 16'($urandom),
                            3'($urandom % 8));
            end
            step(($urandom % 250) == 0, ($urandom % 3) != 0);
        end
        for (int i = 0; i < 20; i++) step(0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Controller that shares the single 16-bit combinational ALU between two requesters (e.g. the execute stage and the address/DMA unit).
- Arbitrates round-robin and registers the granted operands and opcode.
- Holds the ALU inputs stable for a fixed number of cycles per opcode (1 for logic/add/sub, MULDIV_LAT for mult/divide).
- Returns the captured result and carry to the winner on a valid/ready response channel.
- Traps divide-by-zero without driving the ALU.

Parameters:
WIDTH, 16, operand/result width; must match the ALU datapath.
MULDIV_LAT, 4, cycles the ALU inputs are held for opcodes 3'b110 (mult) and 3'b111 (divide); legal range 1..15.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  WIDTH  requester 0 operand a
req0_b  input  WIDTH  requester 0 operand b
req0_op  input  3  requester 0 opcode (ALU select encoding)
req1_valid / req1_ready / req1_a / req1_b / req1_op  same as requester 0, for requester 1
alu_a  output  WIDTH  to ALU operand a
alu_b  output  WIDTH  to ALU operand b
alu_select  output  3  to ALU opcode select
alu_result  input  WIDTH  from ALU result
alu_carry  input  1  from ALU carry (a+b bit 16)
resp_valid  output  1  response available
resp_ready  input  1  consumer takes response
resp_data  output  WIDTH  captured result
resp_carry  output  1  captured carry
resp_err  output  1  1 = divide by zero trapped
resp_id  output  1  requester that issued this op
busy  output  1  state != IDLE

Behaviour:
- Reset (sync): state=IDLE; rr_last=1, so requester 0 wins first. Outputs all 0: alu_a, alu_b, alu_select, resp_valid, resp_data, resp_carry, resp_err, resp_id, busy, req0_ready, req1_ready.
- Reset mid-op: any in-flight operation or pending response is dropped; resp_valid=0 the cycle after reset is sampled.
- States: IDLE, EXEC, RESP.
- IDLE grant (combinational):
  - Only one valid: that requester wins.
  - Both valid: the requester != rr_last wins.
  - reqN_ready = (state==IDLE) && grant==N. At most one ready per cycle; never ready outside IDLE.
- Accept (valid & ready at edge T):
  - Latch a, b, op into op registers; resp_id = N; rr_last = N.
  - If op==3'b111 and b==0: resp_data=16'hFFFF, resp_carry=0, resp_err=1, go to RESP (resp_valid at T+1). The ALU inputs are not updated.
  - Otherwise: cnt = (op is 110/111 ? MULDIV_LAT : 1) - 1, go to EXEC.
- alu_a / alu_b / alu_select are driven directly from the op registers. They change only on a non-trapped accept and hold their value in all other states, including after completion.
- EXEC:
  - cnt!=0: decrement.
  - cnt==0: capture alu_result into resp_data and alu_carry into resp_carry; resp_err=0; go to RESP.
- Latency: accept at T -> resp_valid rises at T+1+L, where L=1 for opcodes 000-101 and L=MULDIV_LAT for 110/111.
- RESP:
  - resp_valid=1; resp_data, resp_carry, resp_err, resp_id held stable until handshake.
  - On resp_ready: resp_valid=0 next cycle, go to IDLE.
  - resp_ready ignored when resp_valid=0.
- No back-to-back overlap: the next accept occurs at the earliest the cycle after the response handshake, in IDLE. A requester's valid stays asserted while it waits; the arbiter does not require this but never drops a held request.
- Width: results are the ALU's WIDTH-bit truncated value; the block performs no arithmetic besides the b==0 compare and the counter.
- busy = (state!=IDLE).

Test Plan:
- Single add: req0 a=16'hFFFF b=16'h0001 op=100 accepted at T -> alu_a/b/select stable from T+1; resp_valid at T+2 with data=16'h0000, carry=1, err=0, id=0.
- Multiply with MULDIV_LAT=4: req1 a=300 b=200 op=110 -> resp_valid at T+5, data=16'hEA60 (60000), id=1; alu inputs unchanged T+1..T+5.
- Divide by zero: req0 a=100 b=0 op=111 -> resp_valid at T+1, data=16'hFFFF, err=1; alu_select keeps its previous value.
- Contention: both valid continuously with op=000 -> grants alternate 0,1,0,1; only one ready per cycle; resp_id sequence 0,1,0,1.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_* stable, no ready to either requester, accept resumes the cycle after resp_ready=1.
- Reset mid-EXEC during a divide -> next cycle state IDLE, resp_valid=0, busy=0, rr_last=1 (req0 wins next).
